// File: rtl/data_memory_pkg.sv
// Shared types and helpers for the handshaked data memory: FSM states, clog2, byte merge, byte parity.
// No logic of its own; latency and backpressure are defined by the modules that import it.
// Functions work on a MAX_DATA_W-wide container; callers size-cast in and out.
package data_memory_pkg;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    localparam int MAX_DATA_W = 1024;

    function automatic int clog2(input int value);
        int r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    function automatic logic [MAX_DATA_W-1:0] byte_merge(
        input logic [MAX_DATA_W-1:0]   old_word,
        input logic [MAX_DATA_W-1:0]   new_word,
        input logic [MAX_DATA_W/8-1:0] byteen
    );
        logic [MAX_DATA_W-1:0] r;
        for (int b = 0; b < MAX_DATA_W/8; b++) begin
            r[8*b +: 8] = byteen[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic parity_byte(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/data_memory_hs_array.sv
// Word storage with byte-enable write and write-first registered read; optional parity via DATA_MEMORY_HS_PARITY_EN.
// Latency: read data valid one cycle after rd_en; rd_zero loads zero instead.
// Backpressure: none here; the read register holds its value while neither rd_en nor rd_zero is set.
module data_memory_hs_array
    import data_memory_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 32,
    parameter int IDX_W  = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX_W-1:0]    idx,
    input  logic                wr_en,
    input  logic [DATA_W-1:0]   wr_dat,
    input  logic [DATA_W/8-1:0] wr_be,
`ifdef DATA_MEMORY_HS_PARITY_EN
    input  logic                par_inj,
    output logic                par_err,
`endif
    input  logic                rd_en,
    input  logic                rd_zero,
    output logic [DATA_W-1:0]   rd_dat
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] cur_word;
    logic [DATA_W-1:0] merged;
    logic [DATA_W-1:0] rd_dat_d;
    logic [DATA_W-1:0] rd_dat_q;
    logic [NB-1:0]     be_eff;

    // The read port sees the merged word so a same-cycle write is returned (write-first).
    always_comb begin
        be_eff   = wr_en ? wr_be : '0;
        cur_word = mem_q[idx];
        merged   = DATA_W'(byte_merge(MAX_DATA_W'(cur_word), MAX_DATA_W'(wr_dat),
                                      (MAX_DATA_W/8)'(be_eff)));
        rd_dat_d = rd_dat_q;
        if (rd_en) begin
            rd_dat_d = merged;
        end else if (rd_zero) begin
            rd_dat_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[idx] <= merged;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_dat_q <= '0;
        end else begin
            rd_dat_q <= rd_dat_d;
        end
    end

    assign rd_dat = rd_dat_q;

`ifdef DATA_MEMORY_HS_PARITY_EN
    logic [NB-1:0] par_q [DEPTH];
    logic [NB-1:0] par_cur;
    logic [NB-1:0] par_merged;
    logic          mismatch;
    logic          par_err_d;
    logic          par_err_q;

    always_comb begin
        par_cur    = par_q[idx];
        par_merged = par_cur;
        mismatch   = 1'b0;
        for (int b = 0; b < NB; b++) begin
            if (be_eff[b]) begin
                par_merged[b] = parity_byte(wr_dat[8*b +: 8]) ^ par_inj;
            end
            mismatch = mismatch | (parity_byte(merged[8*b +: 8]) != par_merged[b]);
        end
        par_err_d = par_err_q;
        if (rd_en) begin
            par_err_d = mismatch;
        end else if (rd_zero) begin
            par_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            par_q[idx] <= par_merged;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
        end
    end

    assign par_err = par_err_q;
`endif

endmodule

// File: rtl/data_memory_hs.sv
// Handshaked data memory with zero-fill sweep, address checking, byte enables; parity via DATA_MEMORY_HS_PARITY_EN.
// Latency: one cycle from request accept to response; sweep takes DEPTH cycles after reset.
// Backpressure: single-entry response register; ReqReady drops while a response is held and RespReady is low.
module data_memory_hs
    import data_memory_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 64
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                ReqValid,
    output logic                ReqReady,
    input  logic                WriteMem,
    input  logic                ReadMem,
    input  logic [ADDR_W-1:0]   Address,
    input  logic [DATA_W-1:0]   DataInput,
    input  logic [DATA_W/8-1:0] ByteEn,
    output logic                RespValid,
    input  logic                RespReady,
    output logic [DATA_W-1:0]   DataOutput,
    output logic                AddrError,
`ifdef DATA_MEMORY_HS_PARITY_EN
    input  logic                ParityInject,
    output logic                ParityError,
`endif
    output logic                InitDone
);

    localparam int NB    = DATA_W / 8;
    localparam int OFFS  = clog2(NB);
    localparam int IDX_W = clog2(DEPTH);
    localparam int TOP   = OFFS + IDX_W;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic              resp_vld_q, resp_vld_d;
    logic              addr_err_q, addr_err_d;

    logic              addr_bad;
    logic              accept;
    logic              has_resp;
    logic [IDX_W-1:0]  arr_idx;
    logic              arr_wr_en;
    logic [DATA_W-1:0] arr_wr_dat;
    logic [NB-1:0]     arr_wr_be;
    logic              arr_rd_en;
    logic              arr_rd_zero;
    logic              arr_par_inj;

    always_comb begin
        addr_bad = (|Address[OFFS-1:0]) || (|Address[ADDR_W-1:TOP]);
        ReqReady = (state_q == ST_RUN) && (!resp_vld_q || RespReady);
        accept   = ReqValid && ReqReady;
        has_resp = accept && (WriteMem || ReadMem);

        state_d     = state_q;
        cnt_d       = cnt_q;
        arr_idx     = Address[TOP-1:OFFS];
        arr_wr_en   = 1'b0;
        arr_wr_dat  = DataInput;
        arr_wr_be   = ByteEn;
        arr_rd_en   = 1'b0;
        arr_rd_zero = 1'b0;
        arr_par_inj = 1'b0;

        if (state_q == ST_INIT) begin
            // Sweep overrides the request path: one zero word per cycle.
            arr_idx    = cnt_q;
            arr_wr_en  = 1'b1;
            arr_wr_dat = '0;
            arr_wr_be  = '1;
            cnt_d      = cnt_q + 1'b1;
            if (cnt_q == IDX_W'(DEPTH - 1)) begin
                state_d = ST_RUN;
            end
        end else begin
            arr_wr_en   = accept && WriteMem && !addr_bad;
            arr_rd_en   = accept && ReadMem && !addr_bad;
            arr_rd_zero = has_resp && !arr_rd_en;
`ifdef DATA_MEMORY_HS_PARITY_EN
            arr_par_inj = ParityInject;
`endif
        end

        resp_vld_d = has_resp ? 1'b1 : (RespReady ? 1'b0 : resp_vld_q);
        addr_err_d = has_resp ? addr_bad : addr_err_q;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= ST_INIT;
            cnt_q      <= '0;
            resp_vld_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            resp_vld_q <= resp_vld_d;
            addr_err_q <= addr_err_d;
        end
    end

    data_memory_hs_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk     (Clk),
        .rst     (Reset),
        .idx     (arr_idx),
        .wr_en   (arr_wr_en),
        .wr_dat  (arr_wr_dat),
        .wr_be   (arr_wr_be),
`ifdef DATA_MEMORY_HS_PARITY_EN
        .par_inj (arr_par_inj),
        .par_err (ParityError),
`endif
        .rd_en   (arr_rd_en),
        .rd_zero (arr_rd_zero),
        .rd_dat  (DataOutput)
    );

`ifndef DATA_MEMORY_HS_PARITY_EN
    logic unused_par_inj;
    assign unused_par_inj = arr_par_inj;
`endif

    assign RespValid = resp_vld_q;
    assign AddrError = addr_err_q;
    assign InitDone  = (state_q == ST_RUN);

endmodule

// File: doc/data_memory_hs.md
Name: data_memory_hs

Overview:
- Parametrised data memory for the 64-bit datapath, replacing the fixed 32x64 array.
- Adds a valid/ready request handshake, per-byte write enables, registered 1-cycle read latency with response backpressure, address checking, and a post-reset zero-fill sweep.
- Sits between the ALU/load-store stage and the register write-back path.

Parameters:
- DATA_W, 64, word width in bits; multiple of 8, minimum 16.
- DEPTH, 32, number of words; power of two, minimum 4.
- ADDR_W, 64, width of the byte address input.

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Reset  in  1  asynchronous, active-high reset.
- ReqValid  in  1  request present.
- ReqReady  out  1  block can accept a request this cycle.
- WriteMem  in  1  request includes a write.
- ReadMem  in  1  request includes a read.
- Address  in  ADDR_W  byte address.
- DataInput  in  DATA_W  write data.
- ByteEn  in  DATA_W/8  per-byte write enable.
- RespValid  out  1  response present.
- RespReady  in  1  consumer accepts the response.
- DataOutput  out  DATA_W  read data.
- AddrError  out  1  response reports a misaligned or out-of-range address.
- InitDone  out  1  zero-fill sweep complete.

Behaviour:
- Clock and reset: one clock, Clk. Reset is asynchronous, active-high.
- Reset values: RespValid=0, DataOutput=0, AddrError=0, InitDone=0, FSM=INIT, sweep counter=0. Memory contents are not reset directly.
- FSM state INIT:
  - Writes 0 to word[counter] each cycle; counter increments.
  - After word DEPTH-1 is written, moves to RUN and InitDone=1 (DEPTH cycles after reset deassert).
  - ReqReady=0 throughout INIT.
- FSM state RUN: ReqReady = !RespValid || RespReady, combinational. There is a single-entry output register.
- Accept: ReqValid && ReqReady at posedge.
  - Accepted with WriteMem=0 and ReadMem=0: no-op, no response.
  - Any other accepted request produces exactly one response.
- Address decode:
  - OFFS = log2(DATA_W/8). Word index = Address[OFFS+log2(DEPTH)-1 : OFFS].
  - Error if Address[OFFS-1:0] != 0, or any Address bit at or above OFFS+log2(DEPTH) is set.
  - On error: no memory write; response has AddrError=1 and DataOutput=0.
- Write: for each byte b with ByteEn[b]=1, mem[idx][8b+7:8b] <= DataInput byte b. Write-only requests respond with AddrError only and DataOutput=0.
- Read: the response appears the cycle after accept (latency 1) with the current word.
- Simultaneous WriteMem and ReadMem: the byte-merged write is applied, and the response returns the merged new word (write-first).
- Read-after-write on consecutive accepted requests returns the new data. No hazard stall is needed.
- Response hold: RespValid stays 1, and DataOutput/AddrError stay stable, until RespReady=1. The response clears on RespReady unless a new accept reloads it in the same cycle.
- Reset mid-operation: any pending response is discarded, the FSM returns to INIT, and the sweep restarts from 0.

Optional Feature:
- Macro: DATA_MEMORY_HS_PARITY_EN.
- Enabled:
  - One even-parity bit is stored per byte and written alongside the data byte (the sweep writes parity 0).
  - On read, a mismatch on any byte sets extra output ParityError=1 with the response; data is still returned.
  - Extra input ParityInject (1 bit): when set on a write, the stored parity is flipped for the written bytes.
- Disabled: no parity storage, and the ports ParityError and ParityInject do not exist.

Decomposition:
- Package data_memory_pkg holds:
  - FSM state enum (INIT, RUN).
  - Function clog2.
  - Function byte_merge(old, new, byteen).
  - Function parity_byte.
- One sub-module, data_memory_hs_array: the storage with registered read port, byte-enable write port, and optional parity bits. The FSM, handshake and decode stay in the top level.

Test Plan:
- Reset deassert, DEPTH=32 -> ReqReady=0 for 32 cycles, then InitDone=1. Reading Address=0x48 returns 0x0000000000000000, AddrError=0.
- Write Address=0x10, DataInput=0x1122334455667788, ByteEn=0xFF; then read 0x10 -> DataOutput=0x1122334455667788 one cycle after accept.
- Write 0x10 with ByteEn=0x01, DataInput=0xAA -> subsequent read returns 0x11223344556677AA.
- Misaligned read 0x13, and out-of-range read 0x100 -> AddrError=1, DataOutput=0, memory unchanged.
- Hold RespReady=0 for 3 cycles after a read -> RespValid and DataOutput stable, ReqReady=0. On RespReady=1 with ReqValid=1, a back-to-back accept gives a new response the next cycle.
- Assert Reset during a pending response and during INIT at counter=10 -> RespValid=0 immediately, and the sweep restarts taking a full 32 cycles.
